// File: rtl/diag_pkg.sv
// Shared definitions for the PE-array diagnostic scan sequencer.
// Optional retry build: define STRAIT_DIAG_RETRY_EN to add the retry states.
package diag_pkg;

    localparam int DIAG_ROWS = 8;
    localparam int DIAG_COLS = 8;

    // Counter width able to hold a full row or column count.
    function automatic int popcnt_width(input int rows, input int cols);
        return $clog2(((rows > cols) ? rows : cols) + 1);
    endfunction

    localparam int DIAG_CNT_W = popcnt_width(DIAG_ROWS, DIAG_COLS);

`ifdef STRAIT_DIAG_RETRY_EN
    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ISSUE       = 3'd1,
        S_WAIT        = 3'd2,
        S_CAPTURE     = 3'd3,
        S_CLASSIFY    = 3'd4,
        S_DONE        = 3'd5,
        S_RETRY_ISSUE = 3'd6,
        S_RETRY_WAIT  = 3'd7
    } diag_state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT     = 3'd2,
        S_CAPTURE  = 3'd3,
        S_CLASSIFY = 3'd4,
        S_DONE     = 3'd5
    } diag_state_e;
`endif

endpackage

// File: rtl/diag_popcount.sv
// Combinational bit counter used to size row and column fault counts.
module diag_popcount
    import diag_pkg::*;
#(
    parameter int W     = DIAG_COLS,
    parameter int OUT_W = DIAG_CNT_W
) (
    input  logic [W-1:0]     bits_i,
    output logic [OUT_W-1:0] count_o
);

    // Sum of set bits in the input vector.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + OUT_W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/diag_scan_sequencer.sv
// Row-by-row self-test sequencer: issues one test run per PE row, builds the
// fault map, then classifies faulty rows/columns into bypass masks.
// Optional retry of failing rows (transient filtering): STRAIT_DIAG_RETRY_EN.
module diag_scan_sequencer
    import diag_pkg::*;
#(
    parameter int ROWS       = DIAG_ROWS,
    parameter int COLS       = DIAG_COLS,
    parameter int ROW_THRESH = 3,
    parameter int COL_THRESH = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      test_req,
    output logic [$clog2(ROWS)-1:0]   row_sel,
    input  logic                      result_valid,
    input  logic [COLS-1:0]           col_fail,
    output logic [ROWS*COLS-1:0]      fault_map,
    output logic [ROWS-1:0]           fault_row_mask,
    output logic [COLS-1:0]           fault_col_mask,
    output logic                      timeout_err
);

    localparam int RW = $clog2(ROWS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = popcnt_width(ROWS, COLS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] ROW_TH   = CW'(ROW_THRESH);
    localparam logic [CW-1:0] COL_TH   = CW'(COL_THRESH);

    diag_state_e          state_q, state_d;
    logic [RW-1:0]        row_q, row_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [COLS-1:0]      vec_q, vec_d;
    logic [ROWS*COLS-1:0] map_q, map_d;
    logic [ROWS-1:0]      rmask_q, rmask_d;
    logic [COLS-1:0]      cmask_q, cmask_d;
    logic                 terr_q, terr_d;
`ifdef STRAIT_DIAG_RETRY_EN
    logic [COLS-1:0]      first_q, first_d;
    logic                 retry_q, retry_d;
    logic                 tout_q, tout_d;
`endif

    logic [CW-1:0]   row_cnt [ROWS];
    logic [CW-1:0]   col_cnt [COLS];
    logic [ROWS-1:0] col_bits [COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        diag_popcount #(.W(COLS), .OUT_W(CW)) u_cnt (
            .bits_i  (map_q[r*COLS +: COLS]),
            .count_o (row_cnt[r])
        );
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        for (genvar r = 0; r < ROWS; r++) begin : g_bit
            assign col_bits[c][r] = map_q[r*COLS + c];
        end
        diag_popcount #(.W(ROWS), .OUT_W(CW)) u_cnt (
            .bits_i  (col_bits[c]),
            .count_o (col_cnt[c])
        );
    end

    // Next-state and datapath update for the scan FSM.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        tmo_d   = tmo_q;
        vec_d   = vec_q;
        map_d   = map_q;
        rmask_d = rmask_q;
        cmask_d = cmask_q;
        terr_d  = terr_q;
`ifdef STRAIT_DIAG_RETRY_EN
        first_d = first_q;
        retry_d = retry_q;
        tout_d  = tout_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    map_d   = '0;
                    rmask_d = '0;
                    cmask_d = '0;
                    terr_d  = 1'b0;
                    row_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_d   = TW'(TIMEOUT);
`ifdef STRAIT_DIAG_RETRY_EN
                retry_d = 1'b0;
                tout_d  = 1'b0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A response on the expiry cycle takes priority over the timeout.
                if (result_valid) begin
                    vec_d   = col_fail;
                    state_d = S_CAPTURE;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                    if (tmo_q == TW'(1)) begin
                        vec_d   = '1;
                        terr_d  = 1'b1;
`ifdef STRAIT_DIAG_RETRY_EN
                        tout_d  = 1'b1;
`endif
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
`ifdef STRAIT_DIAG_RETRY_EN
                if (!retry_q && !tout_q && (vec_q != '0)) begin
                    first_d = vec_q;
                    state_d = S_RETRY_ISSUE;
                end else
`endif
                begin
                    map_d[int'(row_q)*COLS +: COLS] = vec_q;
                    if (row_q == LAST_ROW) begin
                        state_d = S_CLASSIFY;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
`ifdef STRAIT_DIAG_RETRY_EN
            S_RETRY_ISSUE: begin
                tmo_d   = TW'(TIMEOUT);
                retry_d = 1'b1;
                state_d = S_RETRY_WAIT;
            end
            S_RETRY_WAIT: begin
                // Only faults seen on both runs are kept; a lost retry keeps the first run.
                if (result_valid) begin
                    vec_d   = first_q & col_fail;
                    state_d = S_CAPTURE;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                    if (tmo_q == TW'(1)) begin
                        vec_d   = first_q;
                        terr_d  = 1'b1;
                        state_d = S_CAPTURE;
                    end
                end
            end
`endif
            S_CLASSIFY: begin
                for (int r = 0; r < ROWS; r++) rmask_d[r] = (row_cnt[r] >= ROW_TH);
                for (int c = 0; c < COLS; c++) cmask_d[c] = (col_cnt[c] >= COL_TH);
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset clears everything, including the map.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            tmo_q   <= '0;
            vec_q   <= '0;
            map_q   <= '0;
            rmask_q <= '0;
            cmask_q <= '0;
            terr_q  <= 1'b0;
`ifdef STRAIT_DIAG_RETRY_EN
            first_q <= '0;
            retry_q <= 1'b0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            tmo_q   <= tmo_d;
            vec_q   <= vec_d;
            map_q   <= map_d;
            rmask_q <= rmask_d;
            cmask_q <= cmask_d;
            terr_q  <= terr_d;
`ifdef STRAIT_DIAG_RETRY_EN
            first_q <= first_d;
            retry_q <= retry_d;
            tout_q  <= tout_d;
`endif
        end
    end

    assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done           = (state_q == S_DONE);
`ifdef STRAIT_DIAG_RETRY_EN
    assign test_req       = (state_q == S_ISSUE) || (state_q == S_RETRY_ISSUE);
`else
    assign test_req       = (state_q == S_ISSUE);
`endif
    assign row_sel        = row_q;
    assign fault_map      = map_q;
    assign fault_row_mask = rmask_q;
    assign fault_col_mask = cmask_q;
    assign timeout_err    = terr_q;

endmodule

// File: tb/tb_diag_scan_sequencer.sv
// Bench for diag_scan_sequencer: table of per-row responses with expected
// pass results queued at start and checked when done rises.
module tb_diag_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        test_req;
    logic [2:0]  row_sel;
    logic        result_valid;
    logic [7:0]  col_fail;
    logic [63:0] fault_map;
    logic [7:0]  fault_row_mask;
    logic [7:0]  fault_col_mask;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    diag_scan_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .test_req       (test_req),
        .row_sel        (row_sel),
        .result_valid   (result_valid),
        .col_fail       (col_fail),
        .fault_map      (fault_map),
        .fault_row_mask (fault_row_mask),
        .fault_col_mask (fault_col_mask),
        .timeout_err    (timeout_err)
    );

    // One pass: first-run and retry-run vectors per row, response delay per
    // row (0 = never answers), expected results.
    typedef struct {
        logic [7:0][7:0] v1;
        logic [7:0][7:0] v2;
        logic [7:0][7:0] dly;
        logic [63:0]     exp_map;
        logic [7:0]      exp_rm;
        logic [7:0]      exp_cm;
        logic            exp_te;
        int              exp_req;
        int              retry_extra;
    } vec_t;

    typedef struct packed {
        logic [63:0] map;
        logic [7:0]  rm;
        logic [7:0]  cm;
        logic        te;
        int          req;
    } exp_t;

    exp_t exp_q[$];

`ifdef STRAIT_DIAG_RETRY_EN
    localparam int NT = 7;
`else
    localparam int NT = 6;
`endif
    vec_t tbl [NT];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic run_pass(input vec_t t, input int idx);
        int   pulses [8];
        int   nreq;
        int   guard;
        int   d;
        logic [2:0] r;
        logic [7:0] v;
        exp_t e;
        exp_t got;
        foreach (pulses[i]) pulses[i] = 0;
        e.map = t.exp_map;
        e.rm  = t.exp_rm;
        e.cm  = t.exp_cm;
        e.te  = t.exp_te;
`ifdef STRAIT_DIAG_RETRY_EN
        e.req = t.exp_req + t.retry_extra;
`else
        e.req = t.exp_req;
`endif
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("p%0d_busy_rise", idx), busy, 1);
        chk($sformatf("p%0d_done_clr", idx), done, 0);
        nreq  = 0;
        guard = 0;
        while (!done && guard < 3000) begin
            if (test_req) begin
                r = row_sel;
                nreq++;
                d = int'(t.dly[r]);
                v = (pulses[r] == 0) ? t.v1[r] : t.v2[r];
                pulses[r]++;
                if (d != 0) begin
                    repeat (d) @(negedge clk);
                    chk($sformatf("p%0d_row_hold", idx), row_sel, r);
                    result_valid = 1'b1;
                    col_fail     = v;
                    @(negedge clk);
                    result_valid = 1'b0;
                    col_fail     = 8'h00;
                end else begin
                    @(negedge clk);
                end
            end else begin
                @(negedge clk);
            end
            guard++;
        end
        chk($sformatf("p%0d_done", idx), done, 1);
        chk($sformatf("p%0d_busy_low", idx), busy, 0);
        got = exp_q.pop_front();
        chk($sformatf("p%0d_map", idx), fault_map, got.map);
        chk($sformatf("p%0d_row_mask", idx), fault_row_mask, got.rm);
        chk($sformatf("p%0d_col_mask", idx), fault_col_mask, got.cm);
        chk($sformatf("p%0d_timeout_err", idx), timeout_err, got.te);
        chk($sformatf("p%0d_req_pulses", idx), nreq, got.req);
    endtask

    initial begin
        int   guard;
        int   exp_row;
        logic hit;

        // Column fault on column 2 in every row.
        tbl[0].v1 = {8{8'h04}};  tbl[0].v2 = {8{8'h04}};  tbl[0].dly = {8{8'd2}};
        tbl[0].exp_map = {8{8'h04}}; tbl[0].exp_rm = 8'h00; tbl[0].exp_cm = 8'h04;
        tbl[0].exp_te = 1'b0; tbl[0].exp_req = 8; tbl[0].retry_extra = 8;
        // Row 5 with three fails plus an isolated PE in row 1.
        tbl[1].v1 = '0; tbl[1].v1[5] = 8'hE0; tbl[1].v1[1] = 8'h01; tbl[1].v2 = tbl[1].v1;
        tbl[1].dly = {8{8'd2}};
        tbl[1].exp_map = 64'h0000_E000_0000_0100; tbl[1].exp_rm = 8'h20; tbl[1].exp_cm = 8'h00;
        tbl[1].exp_te = 1'b0; tbl[1].exp_req = 8; tbl[1].retry_extra = 2;
        // Row 3 never answers.
        tbl[2].v1 = '0; tbl[2].v2 = '0; tbl[2].dly = {8{8'd2}}; tbl[2].dly[3] = 8'd0;
        tbl[2].exp_map = 64'h0000_0000_FF00_0000; tbl[2].exp_rm = 8'h08; tbl[2].exp_cm = 8'h00;
        tbl[2].exp_te = 1'b1; tbl[2].exp_req = 8; tbl[2].retry_extra = 0;
        // Row 3 answers on the expiry cycle.
        tbl[3].v1 = '0; tbl[3].v1[3] = 8'h81; tbl[3].v2 = tbl[3].v1;
        tbl[3].dly = {8{8'd2}}; tbl[3].dly[3] = 8'd64;
        tbl[3].exp_map = 64'h0000_0000_8100_0000; tbl[3].exp_rm = 8'h00; tbl[3].exp_cm = 8'h00;
        tbl[3].exp_te = 1'b0; tbl[3].exp_req = 8; tbl[3].retry_extra = 1;
        // Rows 0..2 with four fails each, mixed response delays.
        tbl[4].v1 = '0; tbl[4].v1[0] = 8'h0F; tbl[4].v1[1] = 8'h0F; tbl[4].v1[2] = 8'h0F;
        tbl[4].v2 = tbl[4].v1;
        tbl[4].dly = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd1, 8'd9, 8'd1};
        tbl[4].exp_map = 64'h0000_0000_000F_0F0F; tbl[4].exp_rm = 8'h07; tbl[4].exp_cm = 8'h0F;
        tbl[4].exp_te = 1'b0; tbl[4].exp_req = 8; tbl[4].retry_extra = 3;
        // Clean pass; also proves the previous map was cleared.
        tbl[5].v1 = '0; tbl[5].v2 = '0; tbl[5].dly = {8{8'd2}};
        tbl[5].exp_map = 64'h0; tbl[5].exp_rm = 8'h00; tbl[5].exp_cm = 8'h00;
        tbl[5].exp_te = 1'b0; tbl[5].exp_req = 8; tbl[5].retry_extra = 0;
`ifdef STRAIT_DIAG_RETRY_EN
        // Transient filtering: row 2 fails 8'h18 then 8'h08.
        tbl[6].v1 = '0; tbl[6].v1[2] = 8'h18; tbl[6].v2 = '0; tbl[6].v2[2] = 8'h08;
        tbl[6].dly = {8{8'd2}};
        tbl[6].exp_map = 64'h0000_0000_0008_0000; tbl[6].exp_rm = 8'h00; tbl[6].exp_cm = 8'h00;
        tbl[6].exp_te = 1'b0; tbl[6].exp_req = 8; tbl[6].retry_extra = 1;
`endif

        rst = 1'b1; start = 1'b0; result_valid = 1'b0; col_fail = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_test_req", test_req, 0);
        chk("rst_outputs", {fault_map, fault_row_mask, fault_col_mask, timeout_err, row_sel}, 0);

        for (int i = 0; i < NT; i++) run_pass(tbl[i], i);

        // result_valid in DONE must not disturb the held results.
        result_valid = 1'b1; col_fail = 8'hFF;
        @(negedge clk);
        result_valid = 1'b0; col_fail = 8'h00;
        @(negedge clk);
        chk("done_rv_ignored_map", fault_map, tbl[NT-1].exp_map);
        chk("done_hold", done, 1);

        // Mid-pass: start ignored while busy, then reset during WAIT of row 4.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        exp_row = 0; guard = 0; hit = 1'b0;
        while (!hit && guard < 1000) begin
            if (test_req) begin
                chk("mid_row_order", row_sel, exp_row);
                if (row_sel == 3'd4) begin
                    hit = 1'b1;
                end else begin
                    @(negedge clk);
                    start = (exp_row == 2);
                    @(negedge clk);
                    start = 1'b0; result_valid = 1'b1; col_fail = 8'h00;
                    @(negedge clk);
                    result_valid = 1'b0;
                    exp_row++;
                end
            end else begin
                @(negedge clk);
            end
            guard++;
        end
        chk("mid_reached_row4", hit, 1);
        @(negedge clk);
        rst = 1'b1; result_valid = 1'b1; col_fail = 8'hFF;
        @(negedge clk);
        rst = 1'b0; result_valid = 1'b0; col_fail = 8'h00;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_row_sel", row_sel, 0);
        chk("midrst_map", fault_map, 0);
        chk("midrst_masks_err", {fault_row_mask, fault_col_mask, timeout_err}, 0);
        @(negedge clk);
        chk("midrst_idle_no_req", test_req, 0);

        run_pass(tbl[5], 100);
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
